// File: rtl/conv_reg_1d_line_loader.sv
// -----------------------------------------------------------------------------
// conv_reg_1d_line_loader
//
// Builds full image lines for the parallel 1-D convolution core from a
// column-serial stream. Each input beat is one column that holds all IMG_D
// channels. IMG_W beats are assembled into the channel-major packed vector
// that the core reads. There are two line banks used as a ping-pong pair:
// one bank can be filled while the other is presented to the core. An
// opaque 8-bit tag is taken from the first beat of a line and travels with
// that line.
//
// Ports
//   clk         sole clock, rising edge
//   reset       asynchronous reset, active low
//   in_valid    in_data / in_last / in_opaque are valid
//   in_ready    a beat can be accepted (decoded only from registered flags)
//   in_data     one column; channel k at [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]
//   in_last     final column of a line
//   in_opaque   line tag, sampled on the first beat of a line only
//   lines_out   presented line; element (k,w) at
//               [(k*IMG_W+w+1)*DATA_WIDTH-1 : (k*IMG_W+w)*DATA_WIDTH]
//   line_valid  lines_out / opaque_out hold a complete line
//   line_ready  consumer takes the presented line
//   opaque_out  tag of the presented line
//   len_err     one-cycle pulse when in_last disagrees with the column count
// -----------------------------------------------------------------------------
module conv_reg_1d_line_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 32,
    parameter int IMG_D      = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_WIDTH*IMG_D-1:0]       in_data,
    input  logic                              in_last,
    input  logic [7:0]                        in_opaque,
    output logic [DATA_WIDTH*IMG_D*IMG_W-1:0] lines_out,
    output logic                              line_valid,
    input  logic                              line_ready,
    output logic [7:0]                        opaque_out,
    output logic                              len_err
);

    localparam int LINE_BITS = DATA_WIDTH * IMG_D * IMG_W;
    localparam int CNT_W     = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_W - 1);

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

    // Storage and control state
    logic [LINE_BITS-1:0] bank_r [2];
    logic [7:0]           tag_r  [2];
    bank_state_t          bank_state_r     [2];
    bank_state_t          bank_state_nxt_s [2];
    logic                 wr_sel_r;
    logic                 rd_sel_r;
    logic [CNT_W-1:0]     col_cnt_r;
    logic                 len_err_r;

    // Decoded handshake events
    logic [1:0] full_s;
    logic       accept_s;
    logic       last_col_s;
    logic       complete_s;
    logic       short_s;
    logic       drain_s;

    assign full_s[0]  = (bank_state_r[0] == BANK_FULL);
    assign full_s[1]  = (bank_state_r[1] == BANK_FULL);

    // in_ready looks only at registered flags, so it never depends on line_ready.
    assign in_ready   = ~full_s[wr_sel_r];
    assign accept_s   = in_valid & in_ready;
    assign last_col_s = (col_cnt_r == LAST_COL);

    // The column count, not in_last, decides when a line is complete.
    assign complete_s = accept_s & last_col_s;

    // in_last arriving early discards the partial line.
    assign short_s    = accept_s & ~last_col_s & in_last;

    assign line_valid = full_s[rd_sel_r];
    assign drain_s    = line_valid & line_ready;

    assign lines_out  = bank_r[rd_sel_r];
    assign opaque_out = tag_r[rd_sel_r];
    assign len_err    = len_err_r;

    // Next state for each bank's EMPTY/FILLING/FULL life cycle.
    // A fill completion and a drain in the same cycle always hit different
    // banks: the write bank is never FULL while a beat is being accepted.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_state_nxt_s[b] = bank_state_r[b];
            case (bank_state_r[b])
                BANK_EMPTY: begin
                    if (accept_s && (wr_sel_r == 1'(b))) begin
                        if (complete_s) begin
                            bank_state_nxt_s[b] = BANK_FULL;
                        end else if (short_s) begin
                            bank_state_nxt_s[b] = BANK_EMPTY;
                        end else begin
                            bank_state_nxt_s[b] = BANK_FILLING;
                        end
                    end else begin
                        bank_state_nxt_s[b] = BANK_EMPTY;
                    end
                end
                BANK_FILLING: begin
                    if (accept_s && (wr_sel_r == 1'(b))) begin
                        if (complete_s) begin
                            bank_state_nxt_s[b] = BANK_FULL;
                        end else if (short_s) begin
                            bank_state_nxt_s[b] = BANK_EMPTY;
                        end else begin
                            bank_state_nxt_s[b] = BANK_FILLING;
                        end
                    end else begin
                        bank_state_nxt_s[b] = BANK_FILLING;
                    end
                end
                BANK_FULL: begin
                    if (drain_s && (rd_sel_r == 1'(b))) begin
                        bank_state_nxt_s[b] = BANK_EMPTY;
                    end else begin
                        bank_state_nxt_s[b] = BANK_FULL;
                    end
                end
                default: begin
                    bank_state_nxt_s[b] = BANK_EMPTY;
                end
            endcase
        end
    end

    // Bank state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank_state_r[0] <= BANK_EMPTY;
            bank_state_r[1] <= BANK_EMPTY;
        end else begin
            bank_state_r[0] <= bank_state_nxt_s[0];
            bank_state_r[1] <= bank_state_nxt_s[1];
        end
    end

    // Bank pointers, column counter and the length-error pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_sel_r  <= 1'b0;
            rd_sel_r  <= 1'b0;
            col_cnt_r <= '0;
            len_err_r <= 1'b0;
        end else begin
            // len_err is the XOR of "at last column" and in_last: a missing
            // in_last at the end, or an early one, are both flagged.
            len_err_r <= accept_s & (last_col_s ^ in_last);

            if (accept_s) begin
                if (last_col_s || in_last) begin
                    col_cnt_r <= '0;
                end else begin
                    col_cnt_r <= col_cnt_r + CNT_W'(1);
                end
            end

            if (complete_s) begin
                wr_sel_r <= ~wr_sel_r;
            end

            if (drain_s) begin
                rd_sel_r <= ~rd_sel_r;
            end
        end
    end

    // Column write into the active bank, and the tag capture on column 0.
    // Banks are not cleared on drain. A refill overwrites every column, so
    // stale data is never presented as part of a complete line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank_r[0] <= '0;
            bank_r[1] <= '0;
            tag_r[0]  <= 8'h00;
            tag_r[1]  <= 8'h00;
        end else begin
            if (accept_s) begin
                for (int k = 0; k < IMG_D; k++) begin
                    for (int w = 0; w < IMG_W; w++) begin
                        if (col_cnt_r == CNT_W'(w)) begin
                            bank_r[wr_sel_r][(k*IMG_W+w)*DATA_WIDTH +: DATA_WIDTH]
                                <= in_data[k*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                end
                if (col_cnt_r == '0) begin
                    tag_r[wr_sel_r] <= in_opaque;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_reg_1d_line_loader.sv
module tb_conv_reg_1d_line_loader;

    localparam int DW    = 8;
    localparam int IMG_W = 4;
    localparam int IMG_D = 2;
    localparam int LB    = DW * IMG_D * IMG_W;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [DW*IMG_D-1:0] in_data;
    logic               in_last;
    logic [7:0]         in_opaque;
    logic [LB-1:0]      lines_out;
    logic               line_valid;
    logic               line_ready;
    logic [7:0]         opaque_out;
    logic               len_err;

    conv_reg_1d_line_loader #(.DATA_WIDTH(DW), .IMG_W(IMG_W), .IMG_D(IMG_D)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_opaque(in_opaque),
        .lines_out(lines_out), .line_valid(line_valid), .line_ready(line_ready),
        .opaque_out(opaque_out), .len_err(len_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW*IMG_D-1:0] data;
        logic                last;
        logic [7:0]          tag;
    } beat_t;

    typedef struct {
        logic [LB-1:0] bits;
        logic [7:0]    tag;
    } line_t;

    // Stimulus queue and reference model
    beat_t      bq[$];
    line_t      mq[$];
    logic [7:0] cur [IMG_D][IMG_W];
    logic [7:0] cur_tag;
    int         col;
    bit         exp_len_err;

    int n_checks = 0;
    int n_errors = 0;
    int valid_pct = 100;
    int ready_pct = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_lerr = 0;
    bit rec_drains = 0;
    int drain_cyc[$];

    task automatic check_eq(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        col = 0;
        exp_len_err = 0;
        cur_tag = 8'h00;
        for (int k = 0; k < IMG_D; k++)
            for (int w = 0; w < IMG_W; w++)
                cur[k][w] = 8'h00;
    endtask

    // Queue one line: channel 0 = base+w, channel 1 = base+0x10+w.
    task automatic push_line(input int len, input bit last_at_end, input logic [7:0] tag, input logic [7:0] base);
        beat_t b;
        for (int w = 0; w < len; w++) begin
            b.data = {8'(base + 8'h10 + 8'(w)), 8'(base + 8'(w))};
            b.last = last_at_end && (w == len - 1);
            b.tag  = (w == 0) ? tag : 8'($urandom);
            bq.push_back(b);
        end
    endtask

    // One clock cycle: drive, predict, clock, compare.
    task automatic tick();
        bit acc, drn;
        line_t ln;
        in_valid = (bq.size() > 0) && ($urandom_range(99) < valid_pct);
        if (bq.size() > 0) begin
            in_data   = bq[0].data;
            in_last   = bq[0].last;
            in_opaque = bq[0].tag;
        end else begin
            in_data   = 16'($urandom);
            in_last   = 1'b0;
            in_opaque = 8'($urandom);
        end
        line_ready = ($urandom_range(99) < ready_pct);
        // Two banks: input is free whenever fewer than two lines are waiting.
        acc = in_valid && (mq.size() < 2);
        drn = (mq.size() > 0) && line_ready;
        if (in_valid && in_ready) n_acc++;
        if (rec_drains && line_valid && line_ready) drain_cyc.push_back(cyc);
        @(posedge clk);
        cyc++;
        if (drn) void'(mq.pop_front());
        exp_len_err = 0;
        if (acc) begin
            for (int k = 0; k < IMG_D; k++) cur[k][col] = in_data[k*DW +: DW];
            if (col == 0) cur_tag = in_opaque;
            if (col == IMG_W - 1) begin
                for (int k = 0; k < IMG_D; k++)
                    for (int w = 0; w < IMG_W; w++)
                        ln.bits[(k*IMG_W+w)*DW +: DW] = cur[k][w];
                ln.tag = cur_tag;
                mq.push_back(ln);
                exp_len_err = !in_last;
                col = 0;
            end else if (in_last) begin
                exp_len_err = 1;
                col = 0;
            end else begin
                col++;
            end
            void'(bq.pop_front());
        end
        #1;
        check_eq("in_ready", LB'(in_ready), LB'(mq.size() < 2));
        check_eq("line_valid", LB'(line_valid), LB'(mq.size() > 0));
        check_eq("len_err", LB'(len_err), LB'(exp_len_err));
        if (mq.size() > 0) begin
            check_eq("lines_out", lines_out, mq[0].bits);
            check_eq("opaque_out", LB'(opaque_out), LB'(mq[0].tag));
        end
        if (len_err) n_lerr++;
    endtask

    task automatic run_until_empty(input int max);
        int n = 0;
        while (bq.size() > 0 && n < max) begin tick(); n++; end
        check_eq("input_timeout", LB'(bq.size()), LB'(0));
    endtask

    task automatic drain_all(input int max);
        int n = 0;
        valid_pct = 100;
        ready_pct = 100;
        while ((bq.size() > 0 || mq.size() > 0) && n < max) begin tick(); n++; end
        check_eq("drain_timeout", LB'(bq.size() + mq.size()), LB'(0));
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        in_opaque = 8'h00; line_ready = 1'b0;
        model_reset();
        #2;
        check_eq("rst_in_ready", LB'(in_ready), LB'(1));
        check_eq("rst_line_valid", LB'(line_valid), LB'(0));
        check_eq("rst_lines_out", lines_out, LB'(0));
        check_eq("rst_opaque", LB'(opaque_out), LB'(0));
        check_eq("rst_len_err", LB'(len_err), LB'(0));
        @(posedge clk);
        #3 reset = 1'b1;

        // Single line, held by the consumer
        ready_pct = 0; valid_pct = 100;
        push_line(4, 1, 8'hA5, 8'h00);
        run_until_empty(20);
        check_eq("single_valid", LB'(line_valid), LB'(1));
        check_eq("single_data", lines_out, 64'h1312_1110_0302_0100);
        check_eq("single_tag", LB'(opaque_out), LB'(8'hA5));
        tick(); tick();
        check_eq("single_hold", lines_out, 64'h1312_1110_0302_0100);
        drain_all(20);

        // Ping-pong backpressure: three lines, consumer stalled
        ready_pct = 0; valid_pct = 100;
        push_line(4, 1, 8'hB1, 8'h20);
        push_line(4, 1, 8'hB2, 8'h40);
        push_line(4, 1, 8'hB3, 8'h60);
        n_acc = 0;
        for (int i = 0; i < 14; i++) tick();
        check_eq("pp_accepted", LB'(n_acc), LB'(8));
        check_eq("pp_in_ready_low", LB'(in_ready), LB'(0));
        ready_pct = 100; tick(); ready_pct = 0;
        check_eq("pp_in_ready_up", LB'(in_ready), LB'(1));
        check_eq("pp_line2_tag", LB'(opaque_out), LB'(8'hB2));
        drain_all(60);

        // Full-rate stream of five lines
        valid_pct = 100; ready_pct = 100;
        drain_cyc.delete();
        rec_drains = 1;
        for (int l = 0; l < 5; l++) push_line(4, 1, 8'(8'hC0 + l), 8'(8'h80 + 8'(l) * 8'h04));
        drain_all(60);
        tick();
        rec_drains = 0;
        check_eq("fr_lines", LB'(drain_cyc.size()), LB'(5));
        for (int i = 1; i < drain_cyc.size(); i++)
            check_eq("fr_spacing", LB'(drain_cyc[i] - drain_cyc[i-1]), LB'(4));

        // Short line then a proper 0x3C line
        ready_pct = 0; n_lerr = 0;
        push_line(2, 1, 8'hEE, 8'hE0);
        push_line(4, 1, 8'h3C, 8'h50);
        run_until_empty(30);
        tick();
        check_eq("short_len_err", LB'(n_lerr), LB'(1));
        check_eq("short_tag", LB'(opaque_out), LB'(8'h3C));
        check_eq("short_col0", LB'(lines_out[7:0]), LB'(8'h50));
        drain_all(20);

        // Long line: four beats with no in_last
        ready_pct = 0; n_lerr = 0;
        push_line(4, 0, 8'h6D, 8'h30);
        run_until_empty(20);
        tick();
        check_eq("long_len_err", LB'(n_lerr), LB'(1));
        check_eq("long_valid", LB'(line_valid), LB'(1));
        check_eq("long_tag", LB'(opaque_out), LB'(8'h6D));
        drain_all(20);

        // Randomized traffic with occasional short / unterminated lines
        valid_pct = 70; ready_pct = 50;
        for (int l = 0; l < 25; l++) begin
            int r = $urandom_range(9);
            if (r == 0)      push_line($urandom_range(1, IMG_W - 1), 1, 8'($urandom), 8'($urandom));
            else if (r == 1) push_line(IMG_W, 0, 8'($urandom), 8'($urandom));
            else             push_line(IMG_W, 1, 8'($urandom), 8'($urandom));
        end
        run_until_empty(2000);
        drain_all(50);

        // Reset mid-operation: one full bank pending plus two beats
        valid_pct = 100; ready_pct = 0;
        push_line(4, 1, 8'h55, 8'h10);
        push_line(2, 0, 8'h66, 8'h70);
        run_until_empty(20);
        #2 reset = 1'b0;
        #1;
        check_eq("mrst_line_valid", LB'(line_valid), LB'(0));
        check_eq("mrst_lines_out", lines_out, LB'(0));
        check_eq("mrst_opaque", LB'(opaque_out), LB'(0));
        check_eq("mrst_len_err", LB'(len_err), LB'(0));
        check_eq("mrst_in_ready", LB'(in_ready), LB'(1));
        model_reset();
        @(posedge clk); @(posedge clk);
        #2 reset = 1'b1;
        push_line(4, 1, 8'h77, 8'h90);
        run_until_empty(20);
        check_eq("post_rst_data", lines_out, 64'hA3A2_A1A0_9392_9190);
        check_eq("post_rst_tag", LB'(opaque_out), LB'(8'h77));
        drain_all(20);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
